// File: rtl/ours_fifo_rr_arb.sv
// Round-robin drain of NUM_REQ request FIFOs into one registered valid/ready channel.
// Multi-beat packets lock the grant to their owner until the beat carrying LAST is popped.
module ours_fifo_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int LAST_BIT   = 0,
  localparam int SRC_BITS  = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_empty,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_dout,
  input  logic [NUM_REQ-1:0][CTRL_WIDTH-1:0]    req_ctrl,
  output logic [NUM_REQ-1:0]                    req_re,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [CTRL_WIDTH-1:0]                 out_ctrl,
  output logic [SRC_BITS-1:0]                   out_src,
  output logic                                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  state_r;
  logic [SRC_BITS-1:0]     rr_ptr_r;
  logic [SRC_BITS-1:0]     owner_r;
  logic                    out_valid_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [CTRL_WIDTH-1:0]   out_ctrl_r;
  logic [SRC_BITS-1:0]     out_src_r;

  logic                    can_pop_s;
  logic [SRC_BITS-1:0]     sel_s;
  logic                    sel_vld_s;
  logic [SRC_BITS-1:0]     pop_idx_s;
  logic                    pop_s;
  logic                    pop_last_s;
  logic [NUM_REQ-1:0]      req_re_s;

  // Modular add for requester indices; NUM_REQ need not be a power of two.
  function automatic logic [SRC_BITS-1:0] wrap_add(input logic [SRC_BITS-1:0] base,
                                                   input logic [SRC_BITS-1:0] off);
    logic [SRC_BITS:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (SRC_BITS+1)'(NUM_REQ)) begin
      sum = sum - (SRC_BITS+1)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[SRC_BITS-1:0];
  endfunction

  assign can_pop_s = !out_valid_r || out_ready;

  // First non-empty requester starting from rr_ptr.
  always_comb begin
    sel_s     = '0;
    sel_vld_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld_s && !req_empty[wrap_add(rr_ptr_r, SRC_BITS'(i))]) begin
        sel_vld_s = 1'b1;
        sel_s     = wrap_add(rr_ptr_r, SRC_BITS'(i));
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
  end

  // Pop decision: idle picks the round-robin winner, a locked packet only its owner.
  always_comb begin
    pop_idx_s = sel_s;
    pop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pop_idx_s = sel_s;
        pop_s     = can_pop_s && sel_vld_s;
      end
      ST_LOCKED: begin
        pop_idx_s = owner_r;
        pop_s     = can_pop_s && !req_empty[owner_r];
      end
      default: begin
        pop_idx_s = sel_s;
        pop_s     = 1'b0;
      end
    endcase
    if (rst) begin
      pop_s = 1'b0;
    end else begin
      pop_s = pop_s;
    end
  end

  assign pop_last_s = req_ctrl[pop_idx_s][LAST_BIT];

  // One-hot read enable decoded from the pop index.
  always_comb begin
    req_re_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_re_s[i] = pop_s && (pop_idx_s == SRC_BITS'(i));
    end
  end

  // Output register, packet lock FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ctrl_r  <= '0;
      out_src_r   <= '0;
    end else begin
      if (pop_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= req_dout[pop_idx_s];
        out_ctrl_r  <= req_ctrl[pop_idx_s];
        out_src_r   <= pop_idx_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (pop_s && pop_last_s) begin
            rr_ptr_r <= wrap_add(pop_idx_s, SRC_BITS'(1));
          end else if (pop_s) begin
            state_r <= ST_LOCKED;
            owner_r <= pop_idx_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (pop_s && pop_last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= wrap_add(owner_r, SRC_BITS'(1));
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_re    = req_re_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ctrl  = out_ctrl_r;
  assign out_src   = out_src_r;
  assign busy      = (state_r == ST_LOCKED);

  ours_fifo_rr_arb_chk #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_empty (req_empty),
    .req_re    (req_re_s),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_data  (out_data_r),
    .out_ctrl  (out_ctrl_r)
  );

endmodule

// Simulation-only protocol properties of the arbiter.
module ours_fifo_rr_arb_chk #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic [NUM_REQ-1:0]    req_empty,
  input logic [NUM_REQ-1:0]    req_re,
  input logic                  out_valid,
  input logic                  out_ready,
  input logic [DATA_WIDTH-1:0] out_data,
  input logic [CTRL_WIDTH-1:0] out_ctrl
);

  a_re_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_re));

  a_re_not_empty : assert property (@(posedge clk) disable iff (rst)
    ((req_re & req_empty) == '0));

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_ctrl)));

endmodule

// File: doc/ours_fifo_rr_arb.md
# ours_fifo_rr_arb

Round-robin scheduler that drains up to NUM_REQ upstream `ours_fifo_rstn` instances into one shared downstream channel. It drives each FIFO's read enable, captures the popped beat in a single output register, and presents it on a valid/ready interface. Multi-beat packets, delimited by a ctrl "last" bit, are never interleaved. It sits between per-source request FIFOs and a shared ring/bus injection port.

## Interface
- NUM_REQ, 4, number of requester FIFOs; must be ≥2; need not be a power of two.
- DATA_WIDTH, 32, FIFO data width.
- CTRL_WIDTH, 4, FIFO ctrl width.
- LAST_BIT, 0, index in ctrl that marks the final beat of a packet.
- Derived: SRC_BITS = $clog2(NUM_REQ).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_empty  in  NUM_REQ  empty flag of each requester FIFO.
- req_dout  in  NUM_REQ×DATA_WIDTH  head data of each FIFO (combinational from head).
- req_ctrl  in  NUM_REQ×CTRL_WIDTH  head ctrl of each FIFO.
- req_re  out  NUM_REQ  read enable to each FIFO; at most one bit set.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  registered beat data.
- out_ctrl  out  CTRL_WIDTH  registered beat ctrl.
- out_src  out  SRC_BITS  index of the requester that supplied the beat.
- busy  out  1  a packet is in progress (state LOCKED).

## Operation
- can_pop = !out_valid | out_ready.
- States:
  - IDLE: no packet open.
  - LOCKED: owner register holds the requester whose packet is open.
- IDLE select: first requester with !req_empty, scanning rr_ptr, rr_ptr+1, … with explicit wrap from NUM_REQ-1 to 0.
- IDLE pop: if can_pop and a selection exists, assert req_re[sel].
  - If popped req_ctrl[sel][LAST_BIT]=1: stay IDLE; rr_ptr ← sel+1 (wrapped).
  - Else: go LOCKED; owner ← sel; rr_ptr unchanged.
- LOCKED: only the owner is eligible. If can_pop and !req_empty[owner], assert req_re[owner].
  - If the popped beat has LAST=1: go IDLE; rr_ptr ← owner+1 (wrapped).
  - All other requesters wait, even if non-empty.
- Capture on pop: out_data ← req_dout[sel], out_ctrl ← req_ctrl[sel], out_src ← sel, out_valid ← 1. These are sampled in the same cycle req_re is high.
- No pop and out_ready&out_valid: out_valid ← 0. Data regs hold their value.
- No pop and !out_ready: all output regs hold.
- req_re is combinational from state, req_empty, out_valid and out_ready.
  - Forced 0 while rst=1.
  - Never set for an empty FIFO.
- busy = (state == LOCKED).
- Reset values: state IDLE, rr_ptr 0, owner 0, out_valid 0, out_data 0, out_ctrl 0, out_src 0, busy 0, req_re 0.

## Timing
- Pop-to-output latency: 1 cycle. The beat popped in cycle N is presented with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high, including across packet boundaries and requester switches.
- While out_valid=1 and out_ready=0: out_data, out_ctrl and out_src stay stable, and req_re=0.
- A beat is transferred downstream on any cycle with out_valid&out_ready. A new pop may occur in that same cycle.
- Arbitration decision and rr_ptr update happen in the pop cycle. The new rr_ptr applies from the next cycle.
- Owner empty mid-packet: stay LOCKED with no req_re until it refills. No timeout.
- Single-beat packet (LAST on first beat): never enters LOCKED.
- Reset mid-packet: return to IDLE, clear the lock and out_valid. The beat in the output register is discarded. Upstream FIFOs are expected to share the reset.
- Simulation-only assertions:
  - $onehot0(req_re).
  - No req_re to an empty FIFO.
  - out_data and out_ctrl stable while out_valid & !out_ready.

## Test plan
- Reset: hold rst=1 for 2 cycles with all FIFOs non-empty. Required: req_re=0 throughout; out_valid=0 and busy=0 in the cycle after rst drops to 0.
- Round-robin: FIFOs 0–3 each hold one beat with LAST=1, out_ready=1. Required: req_re one-hot 0,1,2,3 on consecutive cycles; out_src 0,1,2,3 one cycle later; final rr_ptr=0.
- Packet lock: rr_ptr=1; FIFO1 holds a 3-beat packet (LAST on beat 3); FIFOs 0 and 2 hold one single-beat packet each. Required: out_src sequence 1,1,1,2,0; busy=1 for exactly 2 cycles.
- Backpressure: deassert out_ready for 5 cycles while out_valid=1. Required: out_* stable and req_re=0 during the stall. After out_ready returns, every beat is delivered once in order, with no loss or duplicate.
- Owner stall: FIFO2 goes empty after beat 1 of a 2-beat packet for 3 cycles while FIFO0 is non-empty. Required: no req_re, busy=1; then beat 2 from FIFO2, then FIFO0.
- Reset mid-packet: assert rst while LOCKED with out_valid=1. Required: next cycle state IDLE, busy=0, out_valid=0, rr_ptr=0.
